heart_rate_monitor: RTL
=======================

# heart_rate_monitor

Beat-statistics stage directly downstream of the QRS detector top level. It consumes the detector's one-bit QRS pulse and measures the RR interval in samples, rejecting pulses inside a refractory window. It keeps an 8-beat moving-average RR and converts that average to beats per minute with a sequential divider. It also raises rate alarms (tachycardia, bradycardia, asystole) for the host.

## Interface
- `DATA_WIDTH`, 16: width of RR, average and BPM values; also the divider iteration count.
- `DIV_NUM`, 12000: 60 × sample rate (200 Hz); the BPM numerator.
- `REFRACT`, 40: minimum accepted RR in samples (200 ms).
- `ASYS`, 800: samples without a beat before `asystole` is raised (4 s).
- `TACHY_BPM`, 100: `tachy` is set when bpm > this value.
- `BRADY_BPM`, 50: `brady` is set when bpm < this value.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  reset; synchronous, active-high (1 = reset).
- `en`  in  1  sample strobe; `qrs` and the interval counter advance only on cycles with `en`=1.
- `qrs`  in  1  QRS pulse from the detector; sampled only when `en`=1.
- `rr_last`  out  DATA_WIDTH  most recent accepted RR interval, in samples.
- `rr_avg`  out  DATA_WIDTH  mean of the last 8 RR intervals.
- `bpm`  out  DATA_WIDTH  DIV_NUM / rr_avg, truncated.
- `bpm_valid`  out  1  one-clock pulse when `bpm` updates.
- `busy`  out  1  high from the UPDATE state through the DONE state.
- `tachy`, `brady`, `asystole`  out  1 each  alarm levels.

## Operation
- States: IDLE, ARMED, UPDATE, AVG, DIVIDE, DONE. Reset puts the FSM in IDLE and clears every output and internal register to 0.
- Interval counter `cnt` runs in every state except IDLE:
  - On an accepted beat, `cnt` is set to 1.
  - On any other `en` cycle, `cnt` increments, saturating at all-ones.
  - On an accepted beat, RR equals the value of `cnt` in that cycle, which is the difference in sample index between the two beats.
- First beat (in IDLE, `en`&`qrs`): go to ARMED and set `cnt`=1. No RR is produced.
- Acceptance rule outside IDLE: `en`&`qrs`&(`cnt` >= REFRACT). Any other `qrs` pulse is ignored and has no effect on any register.
- An accepted beat in ARMED latches `rr_last` and moves to UPDATE.
- UPDATE:
  - On the first RR after IDLE, all 8 ring entries are filled with the RR and sum = 8·RR.
  - Otherwise sum = sum − ring[ptr] + RR, then ring[ptr] = RR, then ptr = ptr+1 (3-bit pointer, wraps 7→0).
  - Sum is DATA_WIDTH+3 bits and never overflows.
- AVG: `rr_avg` = sum >> 3.
- DIVIDE: restoring division of DIV_NUM by `rr_avg`, one quotient bit per clock, DATA_WIDTH clocks. `rr_avg` is at least REFRACT, so it is never 0.
- DONE:
  - Register the quotient into `bpm` and pulse `bpm_valid`.
  - Update `tachy` and `brady` from the new `bpm`.
  - Return to ARMED.
- A beat accepted while `busy` is latched into a 1-deep pending register holding its RR. On leaving DONE, the FSM goes straight to UPDATE with the pending RR. If a third beat is accepted while pending is already full, it overwrites the pending RR (newest wins).
- `asystole` is set in the cycle after `cnt` reaches ASYS while not in IDLE. It is cleared on the next accepted beat.
- Reset asserted in any state, including mid-DIVIDE:
  - Returns the FSM to IDLE, clears all outputs and the ring, and drops any pending beat.
  - No `bpm_valid` is emitted for the aborted computation.

## Timing
- Accepted beat at cycle T:
  - `rr_last` visible at T+1.
  - `rr_avg` visible at T+3.
  - `bpm`, `bpm_valid`, `tachy`, `brady` visible at T+DATA_WIDTH+4 (T+20 at the defaults).
- `busy` is high from T+1 to T+DATA_WIDTH+3 inclusive.
- DIVIDE counts `clk`, not `en`. The divider runs regardless of `en`.
- `bpm_valid` is high for exactly one clock per completed computation.

## Configuration
- `HRM_ALARM_EN` defined: `tachy`, `brady` and `asystole` logic is compiled in and behaves as specified above.
- `HRM_ALARM_EN` undefined:
  - The three alarm ports still exist but are tied to 0.
  - The asystole compare logic is removed.
  - All other behaviour is unchanged.

## Test plan
- Reset then `en`=1 every clock, QRS at samples 0 and 200 → `rr_last`=200, `rr_avg`=200, `bpm`=60 with `bpm_valid` 20 clocks after the second pulse, `tachy`=`brady`=0.
- After the 200-sample fill, feed 8 intervals of 100 → `rr_avg` steps 187, 175, …, 100. Final `bpm`=120 and `tachy`=1.
- Pulse 20 samples after an accepted beat → ignored; the next pulse, 150 samples after that same accepted beat (not after the ignored pulse), gives `rr_last`=150.
- Regular beats, then no QRS for 800 samples → `asystole`=1 one cycle after `cnt`=800. The next QRS clears it. With `HRM_ALARM_EN` undefined, `asystole` stays 0.
- Fill with RR=300 → `bpm`=40, `brady`=1. Assert `rstn` during DIVIDE → all outputs 0, no `bpm_valid`, and the next first pulse only arms the FSM.
- With `en` held 1, a beat is accepted while `busy` → a second `bpm_valid` follows the first, computed with the pending RR.

Source files
------------

// File: rtl/heart_rate_monitor.sv
// RR-interval, 8-beat moving-average and BPM stage fed by the QRS detector pulse.
// Define HRM_ALARM_EN to compile in the tachy/brady/asystole alarm logic; otherwise those ports read 0.
module heart_rate_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_NUM    = 12000,
  parameter int REFRACT    = 40,
  parameter int ASYS       = 800,
  parameter int TACHY_BPM  = 100,
  parameter int BRADY_BPM  = 50
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  qrs,
  output logic [DATA_WIDTH-1:0] rr_last,
  output logic [DATA_WIDTH-1:0] rr_avg,
  output logic [DATA_WIDTH-1:0] bpm,
  output logic                  bpm_valid,
  output logic                  busy,
  output logic                  tachy,
  output logic                  brady,
  output logic                  asystole,
  output logic [2:0]            state_dbg
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 3;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] REFRACT_W = W'(REFRACT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_UPDATE = 3'd2,
    S_AVG    = 3'd3,
    S_DIVIDE = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    rr_last_q, rr_last_d;
  logic [W-1:0]    rr_avg_q, rr_avg_d;
  logic [W-1:0]    bpm_q, bpm_d;
  logic            bpm_valid_q, bpm_valid_d;
  logic            first_q, first_d;
  logic            pend_valid_q, pend_valid_d;
  logic [W-1:0]    pend_rr_q, pend_rr_d;
  logic [W-1:0]    ring_q [8];
  logic [W-1:0]    ring_d [8];
  logic [2:0]      ptr_q, ptr_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;

  logic            accept;
  logic            busy_w;
  logic [W:0]      rem_sh;
  logic [W:0]      rem_sub;

`ifdef HRM_ALARM_EN
  localparam logic [W-1:0] ASYS_W = W'(ASYS);
  logic tachy_q, tachy_d;
  logic brady_q, brady_d;
  logic asys_q, asys_d;
`endif

  assign busy_w  = (state_q == S_UPDATE) || (state_q == S_AVG) ||
                   (state_q == S_DIVIDE) || (state_q == S_DONE);
  assign accept  = (state_q != S_IDLE) && en && qrs && (cnt_q >= REFRACT_W);

  // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, rr_avg_q};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_d    = rr_last_q;
    rr_avg_d     = rr_avg_q;
    bpm_d        = bpm_q;
    bpm_valid_d  = 1'b0;
    first_d      = first_q;
    pend_valid_d = pend_valid_q;
    pend_rr_d    = pend_rr_q;
    ring_d       = ring_q;
    ptr_d        = ptr_q;
    sum_d        = sum_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dcnt_d       = dcnt_q;
`ifdef HRM_ALARM_EN
    tachy_d      = tachy_q;
    brady_d      = brady_q;
    asys_d       = asys_q;
`endif

    if (state_q != S_IDLE) begin
      if (accept)                 cnt_d = W'(1);
      else if (en && cnt_q != '1) cnt_d = cnt_q + W'(1);
    end

    if (accept && busy_w) begin
      pend_valid_d = 1'b1;
      pend_rr_d    = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (en && qrs) begin
          state_d = S_ARMED;
          cnt_d   = W'(1);
          first_d = 1'b1;
        end
      end
      S_ARMED: begin
        if (accept) begin
          rr_last_d = cnt_q;
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (first_q) begin
          for (int i = 0; i < 8; i++) ring_d[i] = rr_last_q;
          sum_d   = {rr_last_q, 3'b000};
          first_d = 1'b0;
        end else begin
          sum_d         = sum_q - SW'(ring_q[ptr_q]) + SW'(rr_last_q);
          ring_d[ptr_q] = rr_last_q;
          ptr_d         = ptr_q + 3'd1;
        end
        state_d = S_AVG;
      end
      S_AVG: begin
        rr_avg_d = sum_q[SW-1:3];
        rem_d    = '0;
        quo_d    = W'(DIV_NUM);
        dcnt_d   = '0;
        state_d  = S_DIVIDE;
      end
      S_DIVIDE: begin
        if (rem_sub[W]) rem_d = rem_sh[W-1:0];
        else            rem_d = rem_sub[W-1:0];
        quo_d  = {quo_q[W-2:0], ~rem_sub[W]};
        dcnt_d = dcnt_q + CW'(1);
        if (dcnt_q == CW'(W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bpm_d       = quo_q;
        bpm_valid_d = 1'b1;
`ifdef HRM_ALARM_EN
        tachy_d     = (quo_q > W'(TACHY_BPM));
        brady_d     = (quo_q < W'(BRADY_BPM));
`endif
        // A beat landing in this very cycle is newer than anything pending.
        if (accept) begin
          rr_last_d    = cnt_q;
          pend_valid_d = 1'b0;
          state_d      = S_UPDATE;
        end else if (pend_valid_q) begin
          rr_last_d    = pend_rr_q;
          pend_valid_d = 1'b0;
          state_d      = S_UPDATE;
        end else begin
          state_d      = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HRM_ALARM_EN
    if (accept)                                       asys_d = 1'b0;
    else if (state_q != S_IDLE && cnt_q >= ASYS_W)    asys_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_last_q    <= '0;
      rr_avg_q     <= '0;
      bpm_q        <= '0;
      bpm_valid_q  <= 1'b0;
      first_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rr_q    <= '0;
      for (int i = 0; i < 8; i++) ring_q[i] <= '0;
      ptr_q        <= '0;
      sum_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dcnt_q       <= '0;
`ifdef HRM_ALARM_EN
      tachy_q      <= 1'b0;
      brady_q      <= 1'b0;
      asys_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      rr_avg_q     <= rr_avg_d;
      bpm_q        <= bpm_d;
      bpm_valid_q  <= bpm_valid_d;
      first_q      <= first_d;
      pend_valid_q <= pend_valid_d;
      pend_rr_q    <= pend_rr_d;
      for (int i = 0; i < 8; i++) ring_q[i] <= ring_d[i];
      ptr_q        <= ptr_d;
      sum_q        <= sum_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dcnt_q       <= dcnt_d;
`ifdef HRM_ALARM_EN
      tachy_q      <= tachy_d;
      brady_q      <= brady_d;
      asys_q       <= asys_d;
`endif
    end
  end

  assign rr_last   = rr_last_q;
  assign rr_avg    = rr_avg_q;
  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;
  assign busy      = busy_w;
  assign state_dbg = state_q;

`ifdef HRM_ALARM_EN
  assign tachy    = tachy_q;
  assign brady    = brady_q;
  assign asystole = asys_q;
`else
  assign tachy    = 1'b0;
  assign brady    = 1'b0;
  assign asystole = 1'b0;
`endif

endmodule
